// File: rtl/bp_tournament.sv
// Tournament branch predictor: gshare and bimodal tables arbitrated by a
// per-PC choice table, with a speculative global history register that is
// repaired from the M-stage snapshot on a misprediction.
module bp_tournament #(
  parameter int         PHT_DEPTH  = 8,
  parameter int         GHR_WIDTH  = 8,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        branchD,
  input  logic        branchM,
  input  logic        pcsrcM,
  input  logic        stall,
  input  logic        flushD,
  input  logic        flushE,
  input  logic        flushM,
  output logic        predF,
  output logic        ready,
  output logic        mispredM
);

  localparam int ENTRIES = 1 << PHT_DEPTH;

  typedef enum logic {INIT, RUN} state_t;

  // Everything a branch needs at resolve time to train the tables and to
  // rebuild the history if it turns out to be mispredicted.
  typedef struct packed {
    logic                 valid;
    logic [PHT_DEPTH-1:0] gidx;
    logic [PHT_DEPTH-1:0] bidx;
    logic [GHR_WIDTH-1:0] ghr;
    logic                 gbit;
    logic                 bbit;
    logic                 pred;
  } pipe_t;

  state_t               state;
  state_t               state_next;
  logic [PHT_DEPTH-1:0] cnt;
  logic [PHT_DEPTH-1:0] cnt_next;

  logic [1:0] pht [ENTRIES];
  logic [1:0] bht [ENTRIES];
  logic [1:0] cpt [ENTRIES];

  logic [GHR_WIDTH-1:0] ghr;

  pipe_t pipe_f;
  pipe_t pipe_d;
  pipe_t pipe_e;
  pipe_t pipe_m;

  logic [PHT_DEPTH-1:0] bidx_f;
  logic [PHT_DEPTH-1:0] gidx_f;
  logic                 gbit_f;
  logic                 bbit_f;
  logic                 choose_g;
  logic                 update_m;
  logic                 shift_d;
  logic                 unused_pc;

  // Only the word-aligned index bits of the PC select table entries.
  assign unused_pc = ^{pcF[31:PHT_DEPTH+2], pcF[1:0]};

  assign bidx_f   = pcF[PHT_DEPTH+1:2];
  assign gidx_f   = bidx_f ^ PHT_DEPTH'(ghr);
  assign gbit_f   = pht[gidx_f][1];
  assign bbit_f   = bht[bidx_f][1];
  assign choose_g = cpt[bidx_f][1];

  assign ready = (state == RUN);
  assign predF = ready & (choose_g ? gbit_f : bbit_f);

  assign pipe_f = '{ready, gidx_f, bidx_f, ghr, gbit_f, bbit_f, predF};

  assign update_m = ready & branchM & pipe_m.valid;
  assign mispredM = update_m & (pipe_m.pred ^ pcsrcM);
  assign shift_d  = ready & branchD & pipe_d.valid;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    if (up) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  // Initialisation walks cnt over every table entry, then hands over to RUN.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == INIT) begin
      cnt_next = cnt + 1'b1;
      if (&cnt) begin
        state_next = RUN;
      end
    end
  end

  // FSM state and initialisation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Table writes: fill during INIT, train on resolved M-stage branches in RUN.
  // Kept out of reset so the tables can map onto RAM.
  always_ff @(posedge clk) begin
    if (!ready) begin
      pht[cnt] <= INIT_STATE;
      bht[cnt] <= INIT_STATE;
      cpt[cnt] <= INIT_STATE;
    end else if (update_m) begin
      pht[pipe_m.gidx] <= sat_step(pht[pipe_m.gidx], pcsrcM);
      bht[pipe_m.bidx] <= sat_step(bht[pipe_m.bidx], pcsrcM);
      if (pipe_m.gbit != pipe_m.bbit) begin
        cpt[pipe_m.bidx] <= sat_step(cpt[pipe_m.bidx], pipe_m.gbit == pcsrcM);
      end
    end
  end

  // Speculative history: repair from the M snapshot wins over a D-stage shift.
  // The width cast keeps the low GHR_WIDTH bits, which also covers a 1-bit GHR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (mispredM) begin
      ghr <= GHR_WIDTH'({pipe_m.ghr, pcsrcM});
    end else if (shift_d) begin
      ghr <= GHR_WIDTH'({ghr, pipe_d.pred});
    end
  end

  // F->D->E->M prediction pipe; stall freezes it, a flush kills the stage it names.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_d <= '0;
      pipe_e <= '0;
      pipe_m <= '0;
    end else begin
      if (!stall) begin
        pipe_d <= pipe_f;
        pipe_e <= pipe_d;
        pipe_m <= pipe_e;
      end
      if (flushD) begin
        pipe_d.valid <= 1'b0;
      end
      if (flushE) begin
        pipe_e.valid <= 1'b0;
      end
      if (flushM) begin
        pipe_m.valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bp_tournament.md
BP_TOURNAMENT -- requirements
Module: bp_tournament

Interface
REQ-001 SHALL have parameter PHT_DEPTH, default 8: log2 entries of the gshare PHT, the bimodal BHT and the choice table (CPT).
REQ-002 SHALL have parameter GHR_WIDTH, default 8: global history bits; legal range 1..PHT_DEPTH.
REQ-003 SHALL have parameter INIT_STATE, default 2'b01: 2-bit counter value written to every table entry during initialisation.
REQ-004 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: pcF input 32, fetch PC; branchD input 1, instruction in D is a branch; branchM input 1, instruction in M is a branch; pcsrcM input 1, actual branch outcome in M.
REQ-006 SHALL have ports: stall input 1, hold all internal pipe registers; flushD, flushE, flushM input 1 each, invalidate that stage's pipe register.
REQ-007 SHALL have ports: predF output 1, taken prediction for pcF; ready output 1, tables initialised; mispredM output 1, M-stage branch was mispredicted.

Function
REQ-008 SHALL use index gidx = pcF[PHT_DEPTH+1:2] XOR zero-extended GHR for the PHT, and bidx = pcF[PHT_DEPTH+1:2] for the BHT and CPT.
REQ-009 SHALL produce predF combinationally: CPT[bidx][1]=1 selects PHT[gidx][1], otherwise BHT[bidx][1]; predF=0 whenever ready=0.
REQ-010 SHALL carry {valid, gidx, bidx, GHR snapshot, gshare bit, bimodal bit, predF} through F->D->E->M pipe registers; all hold when stall=1; flushX clears valid of stage X on the same edge.
REQ-011 SHALL, on a clock edge with branchD=1 and D valid, shift the speculative GHR: GHR <= {GHR[GHR_WIDTH-2:0], predD}.
REQ-012 SHALL, on a clock edge with branchM=1 and M valid, update PHT[gidxM] and BHT[bidxM] by 2-bit saturating step toward pcsrcM (00 and 11 saturate).
REQ-013 SHALL update CPT[bidxM] only when the gshare and bimodal bits in M differ: increment (saturating) if gshare was correct, decrement (saturating) if bimodal was correct.
REQ-014 SHALL assert mispredM combinationally = branchM AND M valid AND (predM XOR pcsrcM).
REQ-015 SHALL, on an edge with mispredM=1, restore GHR <= {GHR_snapshotM[GHR_WIDTH-2:0], pcsrcM}; this overrides a simultaneous REQ-011 shift.
REQ-016 SHALL return the pre-write table value to a same-cycle F read of an entry written by M (write visible next cycle).
REQ-017 SHALL apply GHR_WIDTH=1 as GHR <= predD / pcsrcM (no shift slice).
REQ-018 SHALL implement an FSM with states INIT and RUN; INIT writes INIT_STATE to entry cnt of all three tables, cnt incrementing 0..2^PHT_DEPTH-1, one entry per cycle.
REQ-019 SHALL transition INIT->RUN on the edge that writes entry 2^PHT_DEPTH-1; ready=1 only in RUN; initialisation takes exactly 2^PHT_DEPTH cycles after reset release.
REQ-020 SHALL ignore branchD, branchM and table updates in INIT; mispredM=0 in INIT.
REQ-021 SHALL keep tables out of reset (RAM-inferable); only GHR, pipe registers, FSM and cnt are reset.

Reset
REQ-022 SHALL, while rst=0, asynchronously force: state=INIT, cnt=0, GHR=0, all pipe valid=0, ready=0, predF=0, mispredM=0.
REQ-023 SHALL, on rst asserted mid-RUN or mid-INIT, abandon all activity and restart full initialisation after release.

Verification
REQ-024 Reset release, PHT_DEPTH=8 -> ready=0 for 256 cycles, ready=1 on cycle 256; every entry of all tables reads 2'b01; predF=0 throughout.
REQ-025 Same pcF branch taken 3 times through M, no other branches, GHR constant -> BHT and PHT entries 01->10->11->11; CPT unchanged; predF=1 after second update.
REQ-026 Predicted not-taken branch resolves taken with GHR_snapshotM=8'h5A -> mispredM=1 that cycle; next cycle GHR=8'hB5, even if branchD=1 on that edge.
REQ-027 Gshare bit 1, bimodal bit 0, pcsrcM=1, CPT entry 01 -> CPT 10; repeat with pcsrcM=0 from 00 -> stays 00.
REQ-028 Branch in E with flushE=1 -> reaches M invalid; branchM=1 produces no table write, mispredM=0, GHR unchanged.
REQ-029 rst pulsed low for one cycle at cnt=100 in INIT -> cnt=0, ready=0, full 256-cycle init repeats.
